// File: rtl/encoder_step_counter_pkg.sv
// Shared state encoding, phase codes and the detent transition function
// for the quadrature encoder step counter.
package enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CW1,
    CW2,
    CW3,
    CCW1,
    CCW2,
    CCW3,
    RESYNC
  } enc_state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef struct packed {
    enc_state_t state;
    logic       cw;
    logic       ccw;
    logic       illegal;
  } enc_next_t;

  // One evaluation of the detent tracker; any phase not listed for a state holds it.
  function automatic enc_next_t encNext(input enc_state_t cur, input logic [1:0] s);
    enc_next_t n;
    n.state   = cur;
    n.cw      = 1'b0;
    n.ccw     = 1'b0;
    n.illegal = 1'b0;
    case (cur)
      IDLE: begin
        if (s == PH_10) n.state = CW1;
        else if (s == PH_01) n.state = CCW1;
        else if (s == PH_11) begin
          n.state   = RESYNC;
          n.illegal = 1'b1;
        end
      end
      CW1: begin
        if (s == PH_11) n.state = CW2;
        else if (s == PH_00) n.state = IDLE;
        else if (s == PH_01) begin
          n.state   = RESYNC;
          n.illegal = 1'b1;
        end
      end
      CW2: begin
        if (s == PH_01) n.state = CW3;
        else if (s == PH_10) n.state = CW1;
        else if (s == PH_00) begin
          n.state   = RESYNC;
          n.illegal = 1'b1;
        end
      end
      CW3: begin
        if (s == PH_00) begin
          n.state = IDLE;
          n.cw    = 1'b1;
        end else if (s == PH_11) n.state = CW2;
        else if (s == PH_10) begin
          n.state   = RESYNC;
          n.illegal = 1'b1;
        end
      end
      CCW1: begin
        if (s == PH_11) n.state = CCW2;
        else if (s == PH_00) n.state = IDLE;
        else if (s == PH_10) begin
          n.state   = RESYNC;
          n.illegal = 1'b1;
        end
      end
      CCW2: begin
        if (s == PH_10) n.state = CCW3;
        else if (s == PH_01) n.state = CCW1;
        else if (s == PH_00) begin
          n.state   = RESYNC;
          n.illegal = 1'b1;
        end
      end
      CCW3: begin
        if (s == PH_00) begin
          n.state = IDLE;
          n.ccw   = 1'b1;
        end else if (s == PH_11) n.state = CCW2;
        else if (s == PH_01) begin
          n.state   = RESYNC;
          n.illegal = 1'b1;
        end
      end
      RESYNC: begin
        if (s == PH_00) n.state = IDLE;
      end
      default: n.state = RESYNC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/encoder_step_counter_sync.sv
// Multi-flop synchroniser for one raw encoder pin; cleared by the synchronous reset.
module enc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic synced
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], pin};
  end

  assign synced = chain[SYNC_STAGES-1];

endmodule

// File: rtl/encoder_step_counter.sv
// Quadrature encoder front end: synchronised X/Y, 8-state detent tracker,
// registered CW/CCW/illegal pulses and a wrapping or saturating signed position.
module encoder_step_counter
  import enc_pkg::*;
#(
  parameter int POS_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit WRAP        = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        encInput_X,
  input  logic                        encInput_Y,
  input  logic                        clearPos,
  output logic                        stepCW,
  output logic                        stepCCW,
  output logic                        illegalEdge,
  output logic signed [POS_WIDTH-1:0] position
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic signed [POS_WIDTH:0] MAX_EXT = {2'b00, {(POS_WIDTH-1){1'b1}}};
  localparam logic signed [POS_WIDTH:0] MIN_EXT = {2'b11, {(POS_WIDTH-1){1'b0}}};

  logic                        xSync;
  logic                        ySync;
  logic [1:0]                  s;
  logic [CNT_W-1:0]            settleCnt;
  logic                        settled;
  enc_state_t                  state;
  enc_next_t                   fsmNext;
  logic signed [POS_WIDTH:0]   posExt;
  logic signed [POS_WIDTH:0]   posSum;
  logic signed [POS_WIDTH-1:0] posNext;

  enc_sync #(.SYNC_STAGES(SYNC_STAGES)) syncX (
    .clk    (clk),
    .reset  (reset),
    .pin    (encInput_X),
    .synced (xSync)
  );

  enc_sync #(.SYNC_STAGES(SYNC_STAGES)) syncY (
    .clk    (clk),
    .reset  (reset),
    .pin    (encInput_Y),
    .synced (ySync)
  );

  assign s       = {xSync, ySync};
  assign settled = (settleCnt == '0);

  // The synchroniser is still flushing reset zeros, so its output is not trusted yet.
  always_ff @(posedge clk) begin
    if (reset)          settleCnt <= CNT_W'(SYNC_STAGES);
    else if (!settled)  settleCnt <= settleCnt - CNT_W'(1);
  end

  always_comb begin
    fsmNext = encNext(state, s);
    if (!settled) begin
      fsmNext.state   = state;
      fsmNext.cw      = 1'b0;
      fsmNext.ccw     = 1'b0;
      fsmNext.illegal = 1'b0;
    end
  end

  // One extra bit of headroom lets overflow be detected before wrap or clamp.
  always_comb begin
    posExt = {position[POS_WIDTH-1], position};
    posSum = posExt;
    if (fsmNext.cw)       posSum = posExt + (POS_WIDTH+1)'(1);
    else if (fsmNext.ccw) posSum = posExt - (POS_WIDTH+1)'(1);
    posNext = posSum[POS_WIDTH-1:0];
    if (!WRAP) begin
      if (posSum > MAX_EXT)      posNext = MAX_EXT[POS_WIDTH-1:0];
      else if (posSum < MIN_EXT) posNext = MIN_EXT[POS_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RESYNC;
      stepCW      <= 1'b0;
      stepCCW     <= 1'b0;
      illegalEdge <= 1'b0;
      position    <= '0;
    end else begin
      state       <= fsmNext.state;
      stepCW      <= fsmNext.cw;
      stepCCW     <= fsmNext.ccw;
      illegalEdge <= fsmNext.illegal;
      position    <= clearPos ? '0 : posNext;
    end
  end

endmodule

// File: tb/tb_encoder_step_counter.sv
// Scoreboard bench: directed phase sequences push expected pulses/positions,
// a negedge monitor pops and compares against three parameterisations.
module tb_encoder_step_counter;

  localparam int SYNC    = 2;
  localparam int LATENCY = SYNC + 1;
  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_CW   = 3'b100;
  localparam logic [2:0] K_CCW  = 3'b010;
  localparam logic [2:0] K_ILL  = 3'b001;
  localparam logic [1:0] P00 = 2'b00;
  localparam logic [1:0] P10 = 2'b10;
  localparam logic [1:0] P11 = 2'b11;
  localparam logic [1:0] P01 = 2'b01;

  typedef struct {
    int         tag;
    logic [2:0] kind;
    int         cycle;
    logic [7:0] pos8;
    logic [3:0] posSat;
    logic [3:0] posWrap;
  } exp_t;

  logic clk;
  logic reset;
  logic encX;
  logic encY;
  logic clearPos;

  logic       cw8, ccw8, ill8;
  logic [7:0] pos8;
  logic       cwSat, ccwSat, illSat;
  logic [3:0] posSat;
  logic       cwWrap, ccwWrap, illWrap;
  logic [3:0] posWrap;

  exp_t pulseQ[$];
  exp_t snapQ[$];
  int   cycleCount = 0;
  int   tagSeq = 0;
  int   modelCount = 0;
  logic [3:0] modelSat = '0;
  int   vectorCount = 0;
  int   missCount = 0;
  bit   done = 1'b0;

  encoder_step_counter #(.POS_WIDTH(8), .SYNC_STAGES(SYNC), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .encInput_X(encX), .encInput_Y(encY), .clearPos(clearPos),
    .stepCW(cw8), .stepCCW(ccw8), .illegalEdge(ill8), .position(pos8)
  );

  encoder_step_counter #(.POS_WIDTH(4), .SYNC_STAGES(SYNC), .WRAP(1'b0)) dutSat (
    .clk(clk), .reset(reset), .encInput_X(encX), .encInput_Y(encY), .clearPos(clearPos),
    .stepCW(cwSat), .stepCCW(ccwSat), .illegalEdge(illSat), .position(posSat)
  );

  encoder_step_counter #(.POS_WIDTH(4), .SYNC_STAGES(SYNC), .WRAP(1'b1)) dutWrap (
    .clk(clk), .reset(reset), .encInput_X(encX), .encInput_Y(encY), .clearPos(clearPos),
    .stepCW(cwWrap), .stepCCW(ccwWrap), .illegalEdge(illWrap), .position(posWrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [3:0] satStep(input logic [3:0] p, input int d);
    int t;
    t = int'($signed(p)) + d;
    if (t > 7) t = 7;
    if (t < -8) t = -8;
    return t[3:0];
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one phase; a nonzero kind is the pulse this phase must produce LATENCY cycles later.
  task automatic applyStimulus(input logic [1:0] phase, input int hold, input logic [2:0] kind,
                               input bit clearAtPulse);
    exp_t e;
    encX = phase[1];
    encY = phase[0];
    if (kind != K_NONE) begin
      if (clearAtPulse) begin
        modelCount = 0;
        modelSat   = '0;
      end else if (kind == K_CW) begin
        modelCount++;
        modelSat = satStep(modelSat, 1);
      end else if (kind == K_CCW) begin
        modelCount--;
        modelSat = satStep(modelSat, -1);
      end
      e.tag     = tagSeq;
      e.kind    = kind;
      e.cycle   = cycleCount + LATENCY;
      e.pos8    = modelCount[7:0];
      e.posSat  = modelSat;
      e.posWrap = modelCount[3:0];
      tagSeq++;
      pulseQ.push_back(e);
    end
    if (clearAtPulse) begin
      waitCycles(LATENCY - 1);
      clearPos = 1'b1;
      waitCycles(1);
      clearPos = 1'b0;
      waitCycles(hold - LATENCY);
    end else begin
      waitCycles(hold);
    end
  endtask

  task automatic cwDetent(input bit clr);
    applyStimulus(P10, 4, K_NONE, 1'b0);
    applyStimulus(P11, 4, K_NONE, 1'b0);
    applyStimulus(P01, 4, K_NONE, 1'b0);
    applyStimulus(P00, 4, K_CW, clr);
  endtask

  task automatic ccwDetent();
    applyStimulus(P01, 4, K_NONE, 1'b0);
    applyStimulus(P11, 4, K_NONE, 1'b0);
    applyStimulus(P10, 4, K_NONE, 1'b0);
    applyStimulus(P00, 4, K_CCW, 1'b0);
  endtask

  task automatic snapshot();
    exp_t e;
    e.tag     = tagSeq;
    e.kind    = K_NONE;
    e.cycle   = cycleCount;
    e.pos8    = modelCount[7:0];
    e.posSat  = modelSat;
    e.posWrap = modelCount[3:0];
    tagSeq++;
    snapQ.push_back(e);
    waitCycles(1);
  endtask

  task automatic pulseClear();
    clearPos = 1'b1;
    waitCycles(1);
    clearPos   = 1'b0;
    modelCount = 0;
    modelSat   = '0;
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    waitCycles(n);
    reset      = 1'b0;
    modelCount = 0;
    modelSat   = '0;
  endtask

  // Monitor: every pulse on any DUT must match the head of the scoreboard.
  initial begin
    exp_t e;
    logic [2:0] gotKind, gotSat, gotWrap;
    forever begin
      @(negedge clk);
      gotKind = {cw8, ccw8, ill8};
      gotSat  = {cwSat, ccwSat, illSat};
      gotWrap = {cwWrap, ccwWrap, illWrap};
      if ((gotKind | gotSat | gotWrap) != 3'b000) begin
        if (pulseQ.size() == 0) begin
          checkOutput($sformatf("unexpected pulse @%0d", cycleCount),
                      32'({gotKind, gotSat, gotWrap}), 32'd0);
        end else begin
          e = pulseQ.pop_front();
          checkOutput($sformatf("pulse%0d kind", e.tag), 32'(gotKind), 32'(e.kind));
          checkOutput($sformatf("pulse%0d satKind", e.tag), 32'(gotSat), 32'(e.kind));
          checkOutput($sformatf("pulse%0d wrapKind", e.tag), 32'(gotWrap), 32'(e.kind));
          checkOutput($sformatf("pulse%0d cycle", e.tag), 32'(cycleCount), 32'(e.cycle));
          checkOutput($sformatf("pulse%0d pos8", e.tag), 32'(pos8), 32'(e.pos8));
          checkOutput($sformatf("pulse%0d posSat", e.tag), 32'(posSat), 32'(e.posSat));
          checkOutput($sformatf("pulse%0d posWrap", e.tag), 32'(posWrap), 32'(e.posWrap));
        end
      end
      if (snapQ.size() != 0) begin
        e = snapQ.pop_front();
        checkOutput($sformatf("snap%0d pulses", e.tag), 32'({gotKind, gotSat, gotWrap}), 32'd0);
        checkOutput($sformatf("snap%0d pos8", e.tag), 32'(pos8), 32'(e.pos8));
        checkOutput($sformatf("snap%0d posSat", e.tag), 32'(posSat), 32'(e.posSat));
        checkOutput($sformatf("snap%0d posWrap", e.tag), 32'(posWrap), 32'(e.posWrap));
      end
      if (done) begin
        while (pulseQ.size() != 0) begin
          e = pulseQ.pop_front();
          vectorCount++;
          missCount++;
          $display("[TB] FAIL pulse%0d missing: got no pulse, expected kind %b at cycle %0d",
                   e.tag, e.kind, e.cycle);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: still running at %0t, expected finish before 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    encX     = 1'b0;
    encY     = 1'b0;
    clearPos = 1'b0;
    applyReset(3);
    snapshot();
    applyStimulus(P00, 4, K_NONE, 1'b0);

    $display("[TB] full CW detent");
    cwDetent(1'b0);
    snapshot();

    $display("[TB] clear then three CCW detents");
    pulseClear();
    snapshot();
    repeat (3) ccwDetent();
    snapshot();

    $display("[TB] bounce sequence");
    applyStimulus(P10, 4, K_NONE, 1'b0);
    applyStimulus(P00, 4, K_NONE, 1'b0);
    applyStimulus(P10, 4, K_NONE, 1'b0);
    applyStimulus(P11, 4, K_NONE, 1'b0);
    applyStimulus(P10, 4, K_NONE, 1'b0);
    applyStimulus(P11, 4, K_NONE, 1'b0);
    applyStimulus(P01, 4, K_NONE, 1'b0);
    applyStimulus(P00, 4, K_CW, 1'b0);

    $display("[TB] illegal jump and resync");
    applyStimulus(P11, 4, K_ILL, 1'b0);
    applyStimulus(P01, 4, K_NONE, 1'b0);
    applyStimulus(P11, 4, K_NONE, 1'b0);
    applyStimulus(P00, 4, K_NONE, 1'b0);
    cwDetent(1'b0);
    snapshot();

    $display("[TB] upper saturation and wrap");
    pulseClear();
    repeat (7) cwDetent(1'b0);
    snapshot();
    repeat (2) cwDetent(1'b0);
    snapshot();
    repeat (6) cwDetent(1'b0);
    snapshot();

    $display("[TB] lower saturation and wrap");
    pulseClear();
    repeat (9) ccwDetent();
    snapshot();

    $display("[TB] clear coincident with step");
    pulseClear();
    repeat (5) cwDetent(1'b0);
    snapshot();
    cwDetent(1'b1);
    snapshot();

    $display("[TB] reset mid-detent");
    repeat (2) cwDetent(1'b0);
    applyStimulus(P10, 4, K_NONE, 1'b0);
    applyStimulus(P11, 4, K_NONE, 1'b0);
    applyReset(2);
    snapshot();
    applyStimulus(P11, 4, K_NONE, 1'b0);
    applyStimulus(P01, 4, K_NONE, 1'b0);
    applyStimulus(P00, 6, K_NONE, 1'b0);
    cwDetent(1'b0);
    snapshot();

    waitCycles(6);
    done = 1'b1;
  end

endmodule
